// File: rtl/conv_pkg.sv
// Shared types and helpers for the streaming 2-D convolution engine.
// Dimension math, address-width sizing and fixed-point requantisation live here.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        COMPUTE = 2'd2,
        EMIT    = 2'd3
    } state_t;

    function automatic int odim(input int n, input int k, input int s, input int p);
        return (n + 2 * p - k) / s + 1;
    endfunction

    // Width of an index able to address n entries; never narrower than one bit.
    function automatic int cw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic logic signed [63:0] sat_shift(
        input logic signed [63:0] acc,
        input logic        [4:0]  shift,
        input logic               relu_en,
        input int                 data_w
    );
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r  = acc >>> shift;
        hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (data_w - 1));
        if (relu_en && r < 0) r = '0;
        if (r > hi) r = hi;
        else if (r < lo) r = lo;
        return r;
    endfunction

endpackage

// File: rtl/conv_mac.sv
// Signed multiply-accumulate with synchronous bias preload.
// result is the value the accumulator takes at the next clock edge.
module conv_mac #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] bias,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [ACC_W-1:0]  result
);

    logic signed [ACC_W-1:0]    acc;
    logic signed [2*DATA_W-1:0] prod;

    assign prod = a * b;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        result = acc;
        if (load)    result = ACC_W'(bias);
        else if (en) result = acc + ACC_W'(prod);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc <= '0;
        else        acc <= result;
    end

endmodule

// File: rtl/conv2d_stream.sv
// Streaming 2-D convolution: buffers one frame, then computes each output pixel
// with a single time-multiplexed MAC and emits requantised results over ready/valid.
module conv2d_stream
    import conv_pkg::*;
#(
    parameter int IN_CH    = 1,
    parameter int OUT_CH   = 2,
    parameter int K_ROWS   = 3,
    parameter int K_COLS   = 3,
    parameter int STRIDE_R = 1,
    parameter int STRIDE_C = 1,
    parameter int PAD_R    = 1,
    parameter int PAD_C    = 1,
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 24
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        w_we,
    input  logic [cw(OUT_CH*IN_CH*K_ROWS*K_COLS)-1:0]   w_addr,
    input  logic signed [DATA_W-1:0]                    w_data,
    input  logic                                        b_we,
    input  logic [cw(OUT_CH)-1:0]                       b_addr,
    input  logic signed [DATA_W-1:0]                    b_data,
    input  logic [4:0]                                  shift,
    input  logic                                        relu_en,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic signed [DATA_W-1:0]                    in_data,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic signed [DATA_W-1:0]                    out_data,
    output logic                                        out_last,
    output logic                                        busy
);

    localparam int NW    = OUT_CH * IN_CH * K_ROWS * K_COLS;
    localparam int NPIX  = IN_CH * ROWS * COLS;
    localparam int K     = IN_CH * K_ROWS * K_COLS;
    localparam int OR_N  = odim(ROWS, K_ROWS, STRIDE_R, PAD_R);
    localparam int OC_N  = odim(COLS, K_COLS, STRIDE_C, PAD_C);
    localparam int WA_W  = cw(NW);
    localparam int PI_W  = cw(NPIX);
    localparam int CNT_W = cw(K + 1);
    localparam int CO_W  = cw(OUT_CH);
    localparam int OR_W  = cw(OR_N);
    localparam int OC_W  = cw(OC_N);
    localparam int CI_W  = cw(IN_CH);
    localparam int KR_W  = cw(K_ROWS);
    localparam int KC_W  = cw(K_COLS);

    logic signed [DATA_W-1:0] weights [NW];
    logic signed [DATA_W-1:0] biases  [OUT_CH];
    logic signed [DATA_W-1:0] pix_buf [NPIX];

    state_t           state;
    logic [PI_W-1:0]  wr_idx;
    logic [CNT_W-1:0] cnt;
    logic [CO_W-1:0]  co;
    logic [OR_W-1:0]  orow;
    logic [OC_W-1:0]  ocol;
    logic [CI_W-1:0]  ci;
    logic [KR_W-1:0]  kr;
    logic [KC_W-1:0]  kc;

    logic in_fire;
    logic kc_last, kr_last, ocol_last, orow_last, co_last, pos_last;
    logic mac_load, mac_en;
    logic in_win;
    int   pr, pc, pidx, widx;
    logic signed [DATA_W-1:0] mac_pix;
    logic signed [DATA_W-1:0] mac_w;
    logic signed [ACC_W-1:0]  acc_next;

    assign in_ready  = (state == IDLE) || (state == LOAD);
    assign out_valid = (state == EMIT);
    assign busy      = (state != IDLE);
    assign in_fire   = in_valid && in_ready;

    assign kc_last   = (kc == KC_W'(K_COLS - 1));
    assign kr_last   = (kr == KR_W'(K_ROWS - 1));
    assign ocol_last = (ocol == OC_W'(OC_N - 1));
    assign orow_last = (orow == OR_W'(OR_N - 1));
    assign co_last   = (co == CO_W'(OUT_CH - 1));
    assign pos_last  = co_last && orow_last && ocol_last;

    assign mac_load = (state == COMPUTE) && (cnt == '0);
    assign mac_en   = (state == COMPUTE) && (cnt != '0);

    // Map the current tap onto the unpadded input; taps in the padding read as zero.
    always_comb begin
        pr      = int'(orow) * STRIDE_R + int'(kr) - PAD_R;
        pc      = int'(ocol) * STRIDE_C + int'(kc) - PAD_C;
        in_win  = (pr >= 0) && (pr < ROWS) && (pc >= 0) && (pc < COLS);
        pidx    = in_win ? (int'(ci) * ROWS + pr) * COLS + pc : 0;
        widx    = ((int'(co) * IN_CH + int'(ci)) * K_ROWS + int'(kr)) * K_COLS + int'(kc);
        mac_pix = in_win ? pix_buf[PI_W'(pidx)] : '0;
        mac_w   = weights[WA_W'(widx)];
    end

    conv_mac #(
        .DATA_W(DATA_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (mac_load),
        .en    (mac_en),
        .bias  (biases[co]),
        .a     (mac_pix),
        .b     (mac_w),
        .result(acc_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NW; i++)     weights[i] <= '0;
            for (int i = 0; i < OUT_CH; i++) biases[i]  <= '0;
        end else if (state == IDLE) begin
            if (w_we && int'(w_addr) < NW)     weights[w_addr] <= w_data;
            if (b_we && int'(b_addr) < OUT_CH) biases[b_addr]  <= b_data;
        end
    end

    // NOTE: the frame buffer is deliberately left out of reset; every frame overwrites it in full.
    always_ff @(posedge clk) begin
        if (in_fire) pix_buf[wr_idx] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wr_idx   <= '0;
            cnt      <= '0;
            co       <= '0;
            orow     <= '0;
            ocol     <= '0;
            ci       <= '0;
            kr       <= '0;
            kc       <= '0;
            out_data <= '0;
            out_last <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_fire) begin
                        if (NPIX == 1) begin
                            state <= COMPUTE;
                        end else begin
                            wr_idx <= PI_W'(1);
                            state  <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (in_fire) begin
                        if (wr_idx == PI_W'(NPIX - 1)) begin
                            wr_idx <= '0;
                            state  <= COMPUTE;
                        end else begin
                            wr_idx <= wr_idx + 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    // Cycle 0 preloads the bias; cycles 1..K each consume one tap, kc innermost.
                    if (cnt != '0) begin
                        if (kc_last) begin
                            kc <= '0;
                            if (kr_last) begin
                                kr <= '0;
                                ci <= (ci == CI_W'(IN_CH - 1)) ? '0 : ci + 1'b1;
                            end else begin
                                kr <= kr + 1'b1;
                            end
                        end else begin
                            kc <= kc + 1'b1;
                        end
                    end
                    if (cnt == CNT_W'(K)) begin
                        cnt      <= '0;
                        out_data <= DATA_W'(sat_shift(64'(acc_next), shift, relu_en, DATA_W));
                        out_last <= pos_last;
                        state    <= EMIT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        out_last <= 1'b0;
                        if (pos_last) begin
                            co    <= '0;
                            orow  <= '0;
                            ocol  <= '0;
                            state <= IDLE;
                        end else begin
                            if (ocol_last) begin
                                ocol <= '0;
                                if (orow_last) begin
                                    orow <= '0;
                                    co   <= co + 1'b1;
                                end else begin
                                    orow <= orow + 1'b1;
                                end
                            end else begin
                                ocol <= ocol + 1'b1;
                            end
                            state <= COMPUTE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv2d_stream.sv
// Self-checking bench for conv2d_stream: directed and random frames against a
// plain-arithmetic convolution model, plus a stride-2/no-pad build.
module tb_conv2d_stream;

    localparam int NW   = 18;
    localparam int NPIX = 16;
    localparam int NOUT = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              w_we, b_we, relu_en, in_valid, out_ready;
    logic [4:0]        w_addr;
    logic [0:0]        b_addr;
    logic signed [7:0] w_data, b_data, in_data, out_data;
    logic [4:0]        shift;
    logic              in_ready, out_valid, out_last, busy;

    logic              s_w_we, s_b_we, s_in_valid, s_out_ready;
    logic [4:0]        s_w_addr;
    logic [0:0]        s_b_addr;
    logic signed [7:0] s_w_data, s_b_data, s_in_data, s_out_data;
    logic              s_in_ready, s_out_valid, s_out_last, s_busy;

    int checks = 0;
    int errors = 0;
    int wts [NW];
    int bs  [2];
    int img [NPIX];
    int exp_q [$];

    always #5 clk = ~clk;

    conv2d_stream dut (
        .clk(clk), .rst_n(rst_n),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .b_we(b_we), .b_addr(b_addr), .b_data(b_data),
        .shift(shift), .relu_en(relu_en),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy)
    );

    conv2d_stream #(
        .ROWS(5), .COLS(5), .STRIDE_R(2), .STRIDE_C(2), .PAD_R(0), .PAD_C(0)
    ) dut_s2 (
        .clk(clk), .rst_n(rst_n),
        .w_we(s_w_we), .w_addr(s_w_addr), .w_data(s_w_data),
        .b_we(s_b_we), .b_addr(s_b_addr), .b_data(s_b_data),
        .shift(5'd0), .relu_en(1'b0),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .out_last(s_out_last), .busy(s_busy)
    );

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Direct definition of a padded, strided convolution followed by requantisation.
    function automatic void build_expected(input int sh, input bit relu);
        exp_q.delete();
        for (int co = 0; co < 2; co++)
            for (int orow = 0; orow < 4; orow++)
                for (int ocol = 0; ocol < 4; ocol++) begin
                    longint acc = bs[co];
                    for (int kr = 0; kr < 3; kr++)
                        for (int kc = 0; kc < 3; kc++) begin
                            int r = orow + kr - 1;
                            int c = ocol + kc - 1;
                            if (r >= 0 && r < 4 && c >= 0 && c < 4)
                                acc += longint'(img[r * 4 + c]) * wts[co * 9 + kr * 3 + kc];
                        end
                    acc = acc >>> sh;
                    if (relu && acc < 0) acc = 0;
                    if (acc > 127) acc = 127;
                    if (acc < -128) acc = -128;
                    exp_q.push_back(int'(acc));
                end
    endfunction

    task automatic wr_w(input int a, input int v);
        w_we = 1'b1; w_addr = 5'(a); w_data = 8'(v);
        tick();
        w_we = 1'b0;
    endtask

    task automatic wr_b(input int a, input int v);
        b_we = 1'b1; b_addr = 1'(a); b_data = 8'(v);
        tick();
        b_we = 1'b0;
    endtask

    task automatic program_dut();
        for (int i = 0; i < NW; i++) wr_w(i, wts[i]);
        for (int i = 0; i < 2; i++)  wr_b(i, bs[i]);
    endtask

    task automatic load_frame(input string tag, input bit gaps);
        for (int i = 0; i < NPIX; i++) begin
            int n = 0;
            if (gaps) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) tick();
            end
            in_valid = 1'b1;
            in_data  = 8'(img[i]);
            while (!in_ready && n < 50) begin tick(); n++; end
            check({tag, " in_ready"}, in_ready, 1);
            tick();
        end
        in_valid = 1'b0;
        check({tag, " in_ready drop"}, in_ready, 0);
        check({tag, " busy"}, busy, 1);
    endtask

    task automatic collect(input string tag, input int take, input int stall);
        for (int i = 0; i < take; i++) begin
            int n = 0;
            while (!out_valid && n < 100) begin tick(); n++; end
            if (!out_valid) begin
                check({tag, " timeout"}, out_valid, 1);
                return;
            end
            if (i == stall) begin
                out_ready = 1'b0;
                repeat (5) begin
                    tick();
                    check({tag, " stall valid"}, out_valid, 1);
                    check({tag, " stall data"}, out_data, exp_q[i]);
                end
                out_ready = 1'b1;
            end
            check($sformatf("%s data[%0d]", tag, i), out_data, exp_q[i]);
            check($sformatf("%s last[%0d]", tag, i), out_last, (i == NOUT - 1) ? 1 : 0);
            tick();
        end
        if (take == NOUT) begin
            check({tag, " valid after end"}, out_valid, 0);
            check({tag, " idle after end"}, busy, 0);
        end
    endtask

    task automatic run_frame(input string tag, input int sh, input bit relu, input bit gaps, input int stall);
        shift   = 5'(sh);
        relu_en = relu;
        build_expected(sh, relu);
        load_frame(tag, gaps);
        collect(tag, NOUT, stall);
    endtask

    task automatic fill(input int wv, input int b0, input int b1, input int pv);
        for (int i = 0; i < NW; i++)   wts[i] = wv;
        for (int i = 0; i < NPIX; i++) img[i] = pv;
        bs[0] = b0;
        bs[1] = b1;
    endtask

    task automatic randomise();
        for (int i = 0; i < NW; i++)   wts[i] = int'($urandom_range(255, 0)) - 128;
        for (int i = 0; i < NPIX; i++) img[i] = int'($urandom_range(255, 0)) - 128;
        for (int i = 0; i < 2; i++)    bs[i]  = int'($urandom_range(255, 0)) - 128;
    endtask

    initial begin
        rst_n = 1'b0;
        {w_we, b_we, relu_en, in_valid} = '0;
        out_ready = 1'b1;
        w_addr = '0; b_addr = '0; w_data = '0; b_data = '0; in_data = '0; shift = '0;
        {s_w_we, s_b_we, s_in_valid} = '0;
        s_out_ready = 1'b1;
        s_w_addr = '0; s_b_addr = '0; s_w_data = '0; s_b_data = '0; s_in_data = '0;

        repeat (3) tick();
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset out_last", out_last, 0);
        check("reset out_data", out_data, 0);
        check("reset busy", busy, 0);
        rst_n = 1'b1;
        tick();

        // Identity kernel: centre tap 1 on both output channels.
        fill(0, 0, 0, 0);
        wts[4]  = 1;
        wts[13] = 1;
        for (int i = 0; i < NPIX; i++) img[i] = i;
        program_dut();
        run_frame("identity", 0, 1'b0, 1'b0, -1);

        // Padding profile with a negative bias on channel 1.
        fill(1, 0, -2, 1);
        program_dut();
        run_frame("padding", 0, 1'b0, 1'b0, -1);
        run_frame("shift4", 4, 1'b0, 1'b0, -1);

        fill(127, 0, 0, 127);
        program_dut();
        run_frame("sat_pos", 0, 1'b0, 1'b0, -1);
        fill(-128, 0, 0, 127);
        program_dut();
        run_frame("sat_neg", 0, 1'b0, 1'b0, -1);
        run_frame("relu", 0, 1'b1, 1'b0, -1);

        // Random frames; the same data once clean and once with gaps and a stall.
        for (int f = 0; f < 3; f++) begin
            randomise();
            program_dut();
            run_frame($sformatf("rand%0d", f), int'($urandom_range(12, 0)), 1'(f), 1'b0, -1);
            run_frame($sformatf("rand%0d_bp", f), int'(shift), relu_en, 1'b1, 3);
        end

        // Writes while busy must be ignored.
        randomise();
        program_dut();
        shift = 5'd2; relu_en = 1'b0;
        build_expected(2, 1'b0);
        load_frame("wr_busy", 1'b0);
        wr_w(4, 99);
        wr_b(0, 77);
        collect("wr_busy", NOUT, -1);

        // Abort in the middle of computing output 7.
        load_frame("abort", 1'b0);
        collect("abort", 7, -1);
        check("abort pre busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort out_valid", out_valid, 0);
        check("abort busy", busy, 0);
        check("abort in_ready", in_ready, 1);
        tick();
        rst_n = 1'b1;
        tick();

        // Weights and biases were cleared by the reset.
        for (int i = 0; i < NW; i++) wts[i] = 0;
        bs[0] = 0; bs[1] = 0;
        for (int i = 0; i < NPIX; i++) img[i] = int'($urandom_range(255, 0)) - 128;
        run_frame("cleared", 0, 1'b0, 1'b0, -1);
        randomise();
        program_dut();
        run_frame("reload", 1, 1'b0, 1'b1, -1);

        // Stride-2, unpadded 5x5 build with all-ones data.
        for (int i = 0; i < NW; i++) begin
            s_w_we = 1'b1; s_w_addr = 5'(i); s_w_data = 8'sd1;
            tick();
        end
        s_w_we = 1'b0;
        begin
            int acc_cnt = 0;
            int n = 0;
            s_in_valid = 1'b1;
            s_in_data  = 8'sd1;
            while (acc_cnt < 25 && n < 200) begin
                if (s_in_ready) acc_cnt++;
                tick();
                n++;
            end
            s_in_valid = 1'b0;
            check("s2 frame accepted", acc_cnt, 25);
        end
        for (int i = 0; i < 8; i++) begin
            int n = 0;
            while (!s_out_valid && n < 100) begin tick(); n++; end
            check($sformatf("s2 valid[%0d]", i), s_out_valid, 1);
            check($sformatf("s2 data[%0d]", i), s_out_data, 9);
            check($sformatf("s2 last[%0d]", i), s_out_last, (i == 7) ? 1 : 0);
            tick();
        end
        check("s2 idle after end", s_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv2d_stream.md
Name: conv2d_stream

Overview:
- Sequential, parametrised successor to the combinational conv2d.
- Loads weights and per-output-channel biases through a register write port, and buffers one input feature map received over a ready/valid stream.
- Computes every output pixel with a single time-multiplexed MAC.
- Streams results out with fixed-point requantisation (arithmetic shift, optional ReLU, signed saturation).
- Sits between the image/feature loader and the next layer in the CNN datapath.

Parameters:
IN_CH, 1, input channels
OUT_CH, 2, output channels
K_ROWS, 3, kernel height
K_COLS, 3, kernel width
STRIDE_R, 1, vertical stride
STRIDE_C, 1, horizontal stride
PAD_R, 1, zero rows added on top and on bottom
PAD_C, 1, zero columns added on left and on right
ROWS, 4, input height
COLS, 4, input width
DATA_W, 8, signed data/weight/bias width
ACC_W, 24, signed accumulator width (at least 2*DATA_W + clog2(IN_CH*K_ROWS*K_COLS) + 1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
w_we  in  1  weight write strobe
w_addr  in  clog2(OUT_CH*IN_CH*K_ROWS*K_COLS)  flat index ((co*IN_CH+ci)*K_ROWS+kr)*K_COLS+kc
w_data  in  DATA_W  signed weight
b_we  in  1  bias write strobe
b_addr  in  clog2(OUT_CH)  output channel
b_data  in  DATA_W  signed bias
shift  in  5  right-shift applied to accumulator before saturation
relu_en  in  1  clamp negative results to 0
in_valid  in  1  input pixel valid
in_ready  out  1  input pixel accepted when in_valid && in_ready
in_data  in  DATA_W  signed pixel; order is channel-major, then row, then column
out_valid  out  1  result valid
out_ready  in  1  downstream ready
out_data  out  DATA_W  signed result; order is co, then output row, then output column
out_last  out  1  asserted with the final result of the frame
busy  out  1  high in every state other than IDLE

Behaviour:
- Output dimensions: OR = (ROWS + 2*PAD_R - K_ROWS)/STRIDE_R + 1; OC = (COLS + 2*PAD_C - K_COLS)/STRIDE_C + 1.
- Reset (asynchronous):
  - state = IDLE; all counters = 0.
  - in_ready = 1, out_valid = 0, out_last = 0, out_data = 0, busy = 0.
  - Weight and bias arrays are cleared to 0. The input buffer is not cleared.
- FSM states: IDLE, LOAD, COMPUTE, EMIT.
- IDLE:
  - w_we and b_we are honoured only in IDLE; writes in any other state are ignored.
  - in_ready = 1. The first accepted beat is stored at index 0 and moves the FSM to LOAD.
  - If IN_CH*ROWS*COLS == 1, that first beat goes straight to COMPUTE.
- LOAD:
  - in_ready = 1; each accepted beat is stored and increments the write index.
  - The beat with index IN_CH*ROWS*COLS-1 moves the FSM to COMPUTE; in_ready = 0 from the next cycle.
- COMPUTE:
  - acc is preloaded with sign-extended bias[co].
  - Then one MAC per cycle over ci, kr, kc (kc innermost): acc += pix * w.
  - pix = 0 when the padded coordinate (orow*STRIDE_R+kr-PAD_R, ocol*STRIDE_C+kc-PAD_C) lies outside the input.
  - After IN_CH*K_ROWS*K_COLS MAC cycles, the requantised result is registered into out_data and the FSM moves to EMIT.
  - Latency per output is K+1 cycles, where K = IN_CH*K_ROWS*K_COLS.
- Requantisation:
  - r = acc >>> shift (arithmetic, floor).
  - If relu_en and r < 0, r = 0.
  - Saturate r to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- EMIT:
  - out_valid = 1. out_data and out_last are held stable until out_ready.
  - On handshake:
    - If this was the last output (co = OUT_CH-1, orow = OR-1, ocol = OC-1): go to IDLE. out_last is high during this beat only.
    - Otherwise: advance ocol, then orow, then co, and return to COMPUTE.
  - out_valid drops the cycle after the handshake.
- shift and relu_en are sampled at each requantisation; they must be held stable for the whole frame.
- in_valid outside IDLE/LOAD is ignored; no data is dropped because in_ready = 0 there.
- Reset mid-frame aborts immediately. The next frame must be fully reloaded; weights must be rewritten.

Decomposition:
- Package conv_pkg holds:
  - state enum;
  - functions for output dimension (odim) and clog2 width helpers;
  - a sat_shift function (shift, ReLU, saturate).
- One sub-module, conv_mac: signed multiply-accumulate with a synchronous bias-load and enable, ACC_W wide.

Test Plan:
- Identity: centre weight = 1, others 0 (both co), bias 0, shift 0, input pixel = 4r+c → 32 outputs equal 0..15 twice; out_last on beat 32 only.
- Padding: all weights = 1, input all 1 → per channel, corners 4, edges 6, interior 9; with bias[1] = -2, channel 1 gives corners 2, edges 4, interior 7.
- Saturation and ReLU: weights 127, inputs 127 → all outputs 127. Weights -128 → -128. Same run with relu_en = 1 → 0. shift = 4 with all-ones data: interior 9 → 0.
- Back-pressure: hold out_ready = 0 for 5 cycles on output 3 → out_data/out_valid stable; the full sequence matches the no-stall run; in_valid pulses with gaps during LOAD → same result.
- Reset mid-COMPUTE: assert rst_n = 0 on output 7 → out_valid = 0, busy = 0, in_ready = 1 immediately; reload weights and frame → correct outputs.
- Stride/no-pad build: ROWS = COLS = 5, STRIDE = 2, PAD = 0, all-ones weights and input → OR = OC = 2, four outputs of 9 per channel.
